hilo_md_ctrl: RTL
=================

HILO_MD_CTRL -- requirements
Module: hilo_md_ctrl

Interface
REQ-001 SHALL have port clk input 1: single clock; all state changes on posedge clk.
REQ-002 SHALL have port rst input 1: reset, synchronous, active-high.
REQ-003 SHALL have port start_i input 1: request to begin an operation.
REQ-004 SHALL have port op_i input 2: operation select; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port opA_i input 32: multiplicand / dividend.
REQ-006 SHALL have port opB_i input 32: multiplier / divisor.
REQ-007 SHALL have port cancel_i input 1: pipeline flush; aborts an in-flight operation.
REQ-008 SHALL have port stall_o output 1: pipeline hold request.
REQ-009 SHALL have port busy_o output 1: high in CALC state.
REQ-010 SHALL have port wrn_HILO_o output 1: HI/LO write enable, one-cycle pulse.
REQ-011 SHALL have port wrData_HI_o output 32: value for HI (product high word / remainder).
REQ-012 SHALL have port wrData_LO_o output 32: value for LO (product low word / quotient).
REQ-013 SHALL have port divZero_o output 1: one-cycle pulse on divide by zero.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE.
REQ-015 SHALL, in IDLE with start_i=1 and cancel_i=0, latch op_i, operand magnitudes and result sign flags, clear the 6-bit iteration counter, and enter CALC.
REQ-016 SHALL, in IDLE with start_i=1 and cancel_i=1, ignore the request and remain in IDLE.
REQ-017 SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per CALC cycle, for exactly 32 CALC cycles, then enter DONE.
REQ-018 SHALL assert wrn_HILO_o, with wrData_HI_o/wrData_LO_o valid, during DONE only; DONE lasts one cycle and returns to IDLE.
REQ-019 SHALL give fixed latency: start_i sampled at cycle N, wrn_HILO_o high in cycle N+33.
REQ-020 SHALL drive stall_o = (IDLE and start_i and not cancel_i) or CALC; stall_o is low in DONE.
REQ-021 SHALL produce MULTU as the full 64-bit unsigned product; HI = bits 63:32, LO = bits 31:0.
REQ-022 SHALL produce MULT by multiplying magnitudes and taking the 64-bit two's complement when operand signs differ.
REQ-023 SHALL produce DIVU as LO = quotient, HI = remainder, unsigned.
REQ-024 SHALL produce DIV with quotient negated when operand signs differ and remainder carrying the dividend's sign; 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0 (wrap, no exception).
REQ-025 SHALL, for DIV/DIVU with opB_i=0 at start, skip CALC, enter DONE next cycle with wrn_HILO_o=0, and pulse divZero_o in that DONE cycle.
REQ-026 SHALL, on cancel_i=1 in CALC, return to IDLE next cycle with no HILO write; cancel_i in DONE is ignored and the write completes.
REQ-027 SHALL ignore start_i while in CALC or DONE.
REQ-028 SHALL hold wrData_HI_o/wrData_LO_o at their last values outside DONE.

Reset
REQ-029 SHALL, on rst=1 at posedge clk, enter IDLE and clear counter, operand and accumulator registers, and wrData_HI_o/wrData_LO_o to 0x00000000.
REQ-030 SHALL hold stall_o, busy_o, wrn_HILO_o and divZero_o low during and after reset until a new start; rst mid-operation discards it with no write.

Configuration
REQ-031 SHALL provide the divide datapath only when macro HILO_MD_DIV_EN is defined.
REQ-032 SHALL, without HILO_MD_DIV_EN, treat op_i=10/11 as no-ops: IDLE->DONE in one cycle, wrn_HILO_o=0, divZero_o=0, stall_o high for the start cycle only; multiply behaviour unchanged.

Verification
REQ-033 SHALL check MULTU 0xFFFFFFFF x 0xFFFFFFFF -> cycle N+33 wrn_HILO_o=1, HI=0xFFFFFFFE, LO=0x00000001, stall_o high cycles N..N+32.
REQ-034 SHALL check MULT 0xFFFFFFFE x 0x00000003 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-035 SHALL check DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2.
REQ-036 SHALL check DIV 5/0 -> divZero_o pulse cycle N+1, wrn_HILO_o never asserted, FSM back in IDLE at N+2.
REQ-037 SHALL check cancel_i at cycle N+10 of MULT -> IDLE at N+11, no wrn_HILO_o, new start at N+12 completes at N+45.
REQ-038 SHALL check rst at cycle N+20 of DIVU -> all outputs 0 next cycle, no write; rebuild without HILO_MD_DIV_EN and check DIVU 100/7 yields no write.

Source files
------------

// File: rtl/hilo_md_ctrl.sv
// hilo_md_ctrl: iterative multiply/divide unit that feeds the HI/LO registers.
//
// One shift-add (multiply) or restoring shift-subtract (divide) step per CALC
// cycle. The unit always spends 32 CALC cycles, so a result is written
// exactly 33 cycles after the start request is accepted. Signed operations
// work on magnitudes. The sign is fixed up on the final step, so the result
// registers are loaded with the finished value as the FSM enters DONE.
//
// Optional feature: define HILO_MD_DIV_EN to build the divide datapath.
// Without it, DIV/DIVU go straight from IDLE to DONE and write nothing.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst          synchronous active-high reset
//   start_i      request to begin an operation (honoured only in IDLE)
//   op_i[1:0]    00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   opA_i[31:0]  multiplicand / dividend
//   opB_i[31:0]  multiplier / divisor
//   cancel_i     pipeline flush; aborts an operation in CALC
//   stall_o      pipeline hold request
//   busy_o       high while in CALC
//   wrn_HILO_o   one-cycle HI/LO write enable (DONE only)
//   wrData_HI_o  product high word / remainder
//   wrData_LO_o  product low word / quotient
//   divZero_o    one-cycle pulse on divide by zero

module hilo_md_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] opA_i,
    input  logic [31:0] opB_i,
    input  logic        cancel_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic        wrn_HILO_o,
    output logic [31:0] wrData_HI_o,
    output logic [31:0] wrData_LO_o,
    output logic        divZero_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nx;
    logic [5:0]  cnt;
    logic        neg_q;     // result (product / quotient) must be negated
    logic        skip_q;    // operation entered DONE without computing
    logic        dz_q;      // skipped because of a zero divisor
    logic [31:0] mag_d;     // operand added/subtracted each step
    logic [31:0] acc_hi;    // partial product high / partial remainder
    logic [31:0] acc_lo;    // multiplier bits / dividend-quotient bits
    logic [31:0] wr_hi, wr_lo;
`ifdef HILO_MD_DIV_EN
    logic        is_div_q;
    logic        rem_neg_q; // remainder takes the dividend's sign
`endif

    // Start-request decode
    logic        accept, signed_op, a_neg, b_neg, skip_now, dz_now;
    logic [31:0] mag_a, mag_b;

    always_comb begin
        accept    = start_i & ~cancel_i;
        signed_op = ~op_i[0];
        a_neg     = signed_op & opA_i[31];
        b_neg     = signed_op & opB_i[31];
        mag_a     = a_neg ? (~opA_i + 32'd1) : opA_i;
        mag_b     = b_neg ? (~opB_i + 32'd1) : opB_i;
`ifdef HILO_MD_DIV_EN
        dz_now    = op_i[1] & (opB_i == '0);
        skip_now  = dz_now;
`else
        dz_now    = 1'b0;
        skip_now  = op_i[1];
`endif
    end

    // One iteration step, plus the sign-corrected result of that step
    logic [32:0] sum;
    logic [31:0] step_hi, step_lo;
    logic [63:0] prod_fix;
    logic [31:0] fin_hi, fin_lo;
`ifdef HILO_MD_DIV_EN
    logic [32:0] rem_sh, diff;
`endif

    always_comb begin
        // Multiply: add multiplicand when the low multiplier bit is set,
        // then shift the 65-bit {carry, hi, lo} right by one.
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_d} : 33'd0);
        step_hi = sum[32:1];
        step_lo = {sum[0], acc_lo[31:1]};
`ifdef HILO_MD_DIV_EN
        // Restoring divide: shift {rem, quo} left, trial-subtract divisor.
        // diff[32] set means the trial went negative (keep old remainder).
        rem_sh = {acc_hi, acc_lo[31]};
        diff   = rem_sh - {1'b0, mag_d};
        if (is_div_q) begin
            if (!diff[32]) begin
                step_hi = diff[31:0];
                step_lo = {acc_lo[30:0], 1'b1};
            end else begin
                step_hi = rem_sh[31:0];
                step_lo = {acc_lo[30:0], 1'b0};
            end
        end
`endif
        prod_fix = neg_q ? (~{step_hi, step_lo} + 64'd1) : {step_hi, step_lo};
        fin_hi   = prod_fix[63:32];
        fin_lo   = prod_fix[31:0];
`ifdef HILO_MD_DIV_EN
        if (is_div_q) begin
            fin_lo = neg_q     ? (~step_lo + 32'd1) : step_lo;
            fin_hi = rem_neg_q ? (~step_hi + 32'd1) : step_hi;
        end
`endif
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // FSM next state and control outputs
    always_comb begin
        state_nx   = state;
        stall_o    = 1'b0;
        busy_o     = 1'b0;
        wrn_HILO_o = 1'b0;
        divZero_o  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall_o  = 1'b1;
                    state_nx = skip_now ? DONE : CALC;
                end
            end
            CALC: begin
                busy_o  = 1'b1;
                stall_o = 1'b1;
                if (cancel_i)          state_nx = IDLE;
                else if (cnt == 6'd31) state_nx = DONE;
            end
            DONE: begin
                state_nx   = IDLE;
                wrn_HILO_o = ~skip_q;
                divZero_o  = dz_q;
            end
            default: state_nx = IDLE;
        endcase
        // Control outputs stay quiet for the whole reset cycle
        if (rst) begin
            stall_o    = 1'b0;
            busy_o     = 1'b0;
            wrn_HILO_o = 1'b0;
            divZero_o  = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            neg_q     <= 1'b0;
            skip_q    <= 1'b0;
            dz_q      <= 1'b0;
            mag_d     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            wr_hi     <= '0;
            wr_lo     <= '0;
`ifdef HILO_MD_DIV_EN
            is_div_q  <= 1'b0;
            rem_neg_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt    <= '0;
                        neg_q  <= a_neg ^ b_neg;
                        skip_q <= skip_now;
                        dz_q   <= dz_now;
                        acc_hi <= '0;
`ifdef HILO_MD_DIV_EN
                        is_div_q  <= op_i[1];
                        rem_neg_q <= a_neg;
`endif
                        if (op_i[1]) begin
                            acc_lo <= mag_a;
                            mag_d  <= mag_b;
                        end else begin
                            acc_lo <= mag_b;
                            mag_d  <= mag_a;
                        end
                    end
                end
                CALC: begin
                    if (!cancel_i) begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        cnt    <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            wr_hi <= fin_hi;
                            wr_lo <= fin_lo;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign wrData_HI_o = wr_hi;
    assign wrData_LO_o = wr_lo;

endmodule
